axi_lite_regs: RTL and testbench
================================

AXI_LITE_REGS -- requirements
Module: axi_lite_regs

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and data-bus width; must be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 8: byte-address width.
REQ-003 s_axi_aclk  input  1  sole clock; all state updates on rising edge.
REQ-004 s_axi_aresetn  input  1  reset, asynchronous and active-low.
REQ-005 s_axi_awaddr  input  ADDR_WIDTH  write address; s_axi_awvalid input 1; s_axi_awready output 1.
REQ-006 s_axi_wdata  input  DATA_WIDTH  write data; s_axi_wstrb input DATA_WIDTH/8 byte enables; s_axi_wvalid input 1; s_axi_wready output 1.
REQ-007 s_axi_bresp  output  2  write response; s_axi_bvalid output 1; s_axi_bready input 1.
REQ-008 s_axi_araddr  input  ADDR_WIDTH  read address; s_axi_arvalid input 1; s_axi_arready output 1.
REQ-009 s_axi_rdata  output  DATA_WIDTH  read data; s_axi_rresp output 2; s_axi_rvalid output 1; s_axi_rready input 1.

Function
REQ-010 Block SHALL be the AXI-Lite slave downstream of the bus master port: four DATA_WIDTH registers REG0..REG3 at byte offsets 0x0, 0x4, 0x8, 0xC.
REQ-011 Decode SHALL use addr[ADDR_WIDTH-1:2] as index, ignore addr[1:0]; index >= 4 is out of range.
REQ-012 Response codes SHALL be OKAY = 2'b00 and SLVERR = 2'b10.
REQ-013 Write FSM SHALL have states W_IDLE and W_RESP.
REQ-014 In W_IDLE, awready SHALL be 1 until an address is captured and wready 1 until data is captured; AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-015 When both address and data are held, the block SHALL commit the write on that edge: byte i updated only where wstrb[i] = 1. FSM SHALL enter W_RESP with bvalid = 1 and awready = wready = 0.
REQ-016 Latency: AW and W handshaking in the same cycle SHALL give bvalid = 1 in the following cycle.
REQ-017 Out-of-range write SHALL modify nothing and return bresp = SLVERR; in-range write SHALL return OKAY.
REQ-018 In W_RESP, bvalid and bresp SHALL hold until bready = 1; then the FSM SHALL go to W_IDLE with awready = wready = 1 on the next cycle.
REQ-019 Read FSM SHALL have states R_IDLE (arready = 1) and R_DATA (arready = 0, rvalid = 1).
REQ-020 On an AR handshake, rdata/rresp SHALL be registered and rvalid asserted in the next cycle; all three SHALL hold until rready = 1, then return to R_IDLE.
REQ-021 Out-of-range read SHALL return rdata = 0 and rresp = SLVERR.
REQ-022 A read captured on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-023 Read and write FSMs SHALL be fully independent; neither stalls the other.

Reset
REQ-024 While s_axi_aresetn = 0, all of the following SHALL be 0: awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, REG0..REG3, and the capture flags. Both FSMs SHALL be idle.
REQ-025 awready, wready and arready SHALL rise on the first clock edge after reset release.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately; pending responses and half-captured AW/W SHALL be discarded.

Configuration
REQ-027 Macro AXI_LITE_REGS_CYCLE_COUNTER_EN defined: REG3 SHALL be a read-only free-running counter. It is reset to 0, increments every cycle and wraps from all-ones to 0. Writes to 0xC SHALL change nothing and return SLVERR.
REQ-028 Macro undefined: REG3 SHALL be an ordinary read/write register identical to REG0..REG2, and no counter logic SHALL exist.

Verification
REQ-029 AW 0x4 and W 0xDEADBEEF with wstrb 0xF in the same cycle -> bvalid next cycle, bresp 00. A later read of 0x4 -> rdata 0xDEADBEEF, rresp 00.
REQ-030 W precedes AW by 3 cycles, addr 0x8, data 0x11223344, wstrb 0x5, REG2 previously 0xFFFFFFFF -> read of 0x8 gives 0xFF22FF44.
REQ-031 Write 0x10, then read 0x10 -> bresp 10, rresp 10, rdata 0, all registers unchanged.
REQ-032 bready held low 5 cycles after a write -> bvalid and bresp stable throughout, awready = wready = 0; accepting the response restores both readies next cycle.
REQ-033 Reset pulse while rvalid = 1 and rready = 0 -> rvalid = 0 at once, REG0 reads 0 after release. With AXI_LITE_REGS_CYCLE_COUNTER_EN, two reads of 0xC N cycles apart differ by N, and a write of 0x0 to 0xC -> SLVERR.

Source files
------------

// File: rtl/axi_lite_regs.sv
// rtl/axi_lite_regs.sv - AXI-Lite slave with four byte-strobed registers
// Optional: define AXI_LITE_REGS_CYCLE_COUNTER_EN to make REG3 a read-only cycle counter.
module axi_lite_regs #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [IDX_W-1:0]      awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0] regs_q [4];
    logic [DATA_WIDTH-1:0] regs_d [4];

    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_fire, w_fire, aw_have, w_have, commit;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_ok;
    logic                  ar_fire;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

`ifdef AXI_LITE_REGS_CYCLE_COUNTER_EN
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    assign cnt_d = cnt_q + DATA_WIDTH'(1);
`endif

    // A beat arriving this cycle is merged with any beat already held, so the
    // commit can happen on the same edge the second half arrives.
    assign aw_fire = s_axi_awvalid && awready_q;
    assign w_fire  = s_axi_wvalid && wready_q;
    assign aw_have = aw_held_q || aw_fire;
    assign w_have  = w_held_q || w_fire;
    assign commit  = (w_state_q == W_IDLE) && aw_have && w_have;
    assign wr_idx  = aw_fire ? s_axi_awaddr[ADDR_WIDTH-1:2] : awidx_q;
    assign wr_data = w_fire ? s_axi_wdata : wdata_q;
    assign wr_strb = w_fire ? s_axi_wstrb : wstrb_q;

`ifdef AXI_LITE_REGS_CYCLE_COUNTER_EN
    assign wr_ok = (wr_idx <= IDX_W'(3)) && (wr_idx[1:0] != 2'd3);
`else
    assign wr_ok = (wr_idx <= IDX_W'(3));
`endif

    assign ar_fire     = s_axi_arvalid && arready_q;
    assign rd_idx      = s_axi_araddr[ADDR_WIDTH-1:2];
    assign rd_in_range = (rd_idx <= IDX_W'(3));

    always_comb begin
        rd_val = '0;
        if (rd_in_range) begin
            rd_val = regs_q[rd_idx[1:0]];
`ifdef AXI_LITE_REGS_CYCLE_COUNTER_EN
            if (rd_idx[1:0] == 2'd3) begin
                rd_val = cnt_q;
            end
`endif
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
`ifdef AXI_LITE_REGS_CYCLE_COUNTER_EN
            cnt_q     <= '0;
`endif
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
`ifdef AXI_LITE_REGS_CYCLE_COUNTER_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_have && w_have) w_state_d = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                awidx_d   = wr_idx;
                wdata_d   = wr_data;
                wstrb_d   = wr_strb;
                aw_held_d = aw_have;
                w_held_d  = w_have;
                awready_d = !aw_have;
                wready_d  = !w_have;
                if (commit) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    regs_d[wr_idx[1:0]][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_fire) r_state_d = R_DATA;
            R_DATA:  if (s_axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data is sampled from regs_q, so a same-edge write is not visible yet.
    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_fire) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_val;
                    rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_regs.sv
// tb/tb_axi_lite_regs.sv - directed self-checking bench for axi_lite_regs
module tb_axi_lite_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_checks = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_lite_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs, w_hs;
        int to = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && to < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1; end
            to++;
        end
        while (!bvalid && to < 20) begin
            tick();
            to++;
        end
        check("wr_done", {31'b0, to < 20}, 32'd1);
        resp = bresp;
        tick();
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hs;
        int to = 0;
        araddr = a; arvalid = 1'b1;
        hs = 0;
        while (!hs && to < 20) begin
            hs = arready;
            tick();
            to++;
        end
        arvalid = 1'b0;
        while (!rvalid && to < 20) begin
            tick();
            to++;
        end
        check("rd_done", {31'b0, to < 20}, 32'd1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;
`ifdef AXI_LITE_REGS_CYCLE_COUNTER_EN
    logic [31:0] c1, c2;
`endif

    initial begin
        repeat (3) tick();
        check("rst_awready", {31'b0, awready}, 0);
        check("rst_wready", {31'b0, wready}, 0);
        check("rst_arready", {31'b0, arready}, 0);
        check("rst_bvalid", {31'b0, bvalid}, 0);
        check("rst_rvalid", {31'b0, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;
        tick();
        check("rel_awready", {31'b0, awready}, 1);
        check("rel_wready", {31'b0, wready}, 1);
        check("rel_arready", {31'b0, arready}, 1);

        // Same-cycle AW+W: response one cycle later
        awaddr = 8'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("same_bvalid", {31'b0, bvalid}, 1);
        check("same_bresp", {30'b0, bresp}, 0);
        check("same_awready", {31'b0, awready}, 0);
        check("same_wready", {31'b0, wready}, 0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("same_bdone", {31'b0, bvalid}, 0);
        check("same_awready_back", {31'b0, awready}, 1);
        axi_read(8'h04, rd, resp);
        check("reg1_rdata", rd, 32'hDEADBEEF);
        check("reg1_rresp", {30'b0, resp}, 0);

        // W three cycles ahead of AW, partial strobes
        axi_write(8'h08, 32'hFFFFFFFF, 4'hF, resp);
        check("reg2_init_bresp", {30'b0, resp}, 0);
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready", {31'b0, wready}, 0);
        check("wfirst_awready", {31'b0, awready}, 1);
        check("wfirst_bvalid", {31'b0, bvalid}, 0);
        repeat (2) tick();
        awaddr = 8'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("wfirst_bvalid_after_aw", {31'b0, bvalid}, 1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(8'h08, rd, resp);
        check("reg2_strobed", rd, 32'hFF22FF44);

        // Out-of-range access
        axi_write(8'h10, 32'h12345678, 4'hF, resp);
        check("oor_bresp", {30'b0, resp}, 2);
        axi_read(8'h10, rd, resp);
        check("oor_rdata", rd, 0);
        check("oor_rresp", {30'b0, resp}, 2);
        axi_read(8'h00, rd, resp);
        check("oor_reg0", rd, 0);
        axi_read(8'h04, rd, resp);
        check("oor_reg1", rd, 32'hDEADBEEF);
        axi_read(8'h08, rd, resp);
        check("oor_reg2", rd, 32'hFF22FF44);

        // Low address bits are ignored
        axi_write(8'h03, 32'hA5A5A5A5, 4'h3, resp);
        check("lowbits_bresp", {30'b0, resp}, 0);
        axi_read(8'h01, rd, resp);
        check("lowbits_reg0", rd, 32'h0000A5A5);

`ifdef AXI_LITE_REGS_CYCLE_COUNTER_EN
        araddr = 8'h0C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        c1 = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        repeat (8) tick();
        araddr = 8'h0C; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        c2 = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("cnt_delta", c2 - c1, 32'd10);
        axi_write(8'h0C, 32'h0, 4'hF, resp);
        check("cnt_wr_bresp", {30'b0, resp}, 2);
`else
        axi_read(8'h0C, rd, resp);
        check("oor_reg3", rd, 0);
        axi_write(8'h0C, 32'h1234ABCD, 4'hF, resp);
        check("reg3_bresp", {30'b0, resp}, 0);
        axi_read(8'h0C, rd, resp);
        check("reg3_rdata", rd, 32'h1234ABCD);
`endif

        // Back-pressure on B for five cycles
        awaddr = 8'h00; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", {31'b0, bvalid}, 1);
            check("bp_bresp", {30'b0, bresp}, 0);
            check("bp_readies", {30'b0, awready, wready}, 0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bp_readies_back", {30'b0, awready, wready}, 32'd3);
        check("bp_bdone", {31'b0, bvalid}, 0);
        axi_read(8'h00, rd, resp);
        check("bp_reg0", rd, 32'hCAFEF00D);

        // Read and write of REG1 on the same edge
        awaddr = 8'h04; wdata = 32'h0BADF00D; wstrb = 4'hF;
        araddr = 8'h04;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_bvalid", {31'b0, bvalid}, 1);
        check("rw_rvalid", {31'b0, rvalid}, 1);
        check("rw_old_data", rdata, 32'hDEADBEEF);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        axi_read(8'h04, rd, resp);
        check("rw_new_data", rd, 32'h0BADF00D);

        // Reset mid-transaction: pending R and half-captured W are dropped
        araddr = 8'h00; arvalid = 1'b1;
        wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; wvalid = 1'b0;
        check("mid_rvalid", {31'b0, rvalid}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'b0, rvalid}, 0);
        check("mid_rst_readies", {29'b0, awready, wready, arready}, 0);
        check("mid_rst_rdata", rdata, 0);
        tick();
        rst_n = 1'b1;
        tick();
        awaddr = 8'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mid_halfw_dropped", {31'b0, bvalid}, 0);
        check("mid_wready", {31'b0, wready}, 1);
        wdata = 32'h00000099; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("mid_bvalid", {31'b0, bvalid}, 1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(8'h00, rd, resp);
        check("mid_reg0_zero", rd, 0);
        axi_read(8'h04, rd, resp);
        check("mid_reg1", rd, 32'h00000099);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
